// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 for the single-cycle MIPS core: Status/Cause/EPC/Count/Compare,
// MFC0/MTC0 access, exception arbitration and EPC capture.
module cp0_exception_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        IsCOP0,
  input  logic        IsEret,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        syscall,
  input  logic        ri,
  input  logic        ov,
  input  logic [4:0]  ext_int,
  output logic [31:0] cp0_rdata,
  output logic        HasExp,
  output logic [31:0] epc,
  output logic        exl
);

  localparam logic [4:0] AddrCount   = 5'd9;
  localparam logic [4:0] AddrCompare = 5'd11;
  localparam logic [4:0] AddrStatus  = 5'd12;
  localparam logic [4:0] AddrCause   = 5'd13;
  localparam logic [4:0] AddrEpc     = 5'd14;

  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic [7:0]  im_q, im_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  ip_hw_q, ip_hw_d;
  logic        timer_pend_q, timer_pend_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;

  logic [7:0]  ip;
  logic        int_req;
  logic [4:0]  win_code;

  assign ip      = {timer_pend_q, ip_hw_q, ip_sw_q};
  assign int_req = ie_q & ~exl_q & |(ip & im_q);
  assign HasExp  = int_req | syscall | ri | ov;
  assign epc     = epc_q;
  assign exl     = exl_q;

  always_comb begin
    if (int_req)     win_code = 5'd0;
    else if (ov)     win_code = 5'd12;
    else if (ri)     win_code = 5'd10;
    else             win_code = 5'd8;
  end

  always_comb begin
    unique case (cp0_addr)
      AddrCount:   cp0_rdata = count_q;
      AddrCompare: cp0_rdata = compare_q;
      AddrStatus:  cp0_rdata = {16'h0, im_q, 6'h0, exl_q, ie_q};
      AddrCause:   cp0_rdata = {16'h0, ip, 1'b0, exc_code_q, 2'b00};
      AddrEpc:     cp0_rdata = epc_q;
      default:     cp0_rdata = 32'h0;
    endcase
  end

  always_comb begin
    ie_d         = ie_q;
    exl_d        = exl_q;
    im_d         = im_q;
    exc_code_d   = exc_code_q;
    ip_sw_d      = ip_sw_q;
    ip_hw_d      = ext_int;
    timer_pend_d = timer_pend_q | (count_q == compare_q);
    epc_d        = epc_q;
    count_d      = count_q + 32'd1;
    compare_d    = compare_q;

    if (HasExp) begin
      // The faulting instruction never commits, so MTC0/ERET are dropped here.
      exc_code_d = win_code;
      exl_d      = 1'b1;
      if (!exl_q) epc_d = pc;
    end else begin
      if (mtc0_we) begin
        unique case (cp0_addr)
          AddrCount:   count_d = cp0_wdata;
          AddrCompare: begin
            compare_d    = cp0_wdata;
            timer_pend_d = 1'b0;
          end
          AddrStatus:  begin
            ie_d  = cp0_wdata[0];
            exl_d = cp0_wdata[1];
            im_d  = cp0_wdata[15:8];
          end
          AddrCause:   ip_sw_d = cp0_wdata[9:8];
          AddrEpc:     epc_d = cp0_wdata;
          default:     ;
        endcase
      end
      if (IsCOP0 && IsEret) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie_q         <= 1'b0;
      exl_q        <= 1'b0;
      im_q         <= 8'h0;
      exc_code_q   <= 5'h0;
      ip_sw_q      <= 2'h0;
      ip_hw_q      <= 5'h0;
      timer_pend_q <= 1'b0;
      epc_q        <= 32'h0;
      count_q      <= 32'h0;
      compare_q    <= 32'hFFFF_FFFF;
    end else begin
      ie_q         <= ie_d;
      exl_q        <= exl_d;
      im_q         <= im_d;
      exc_code_q   <= exc_code_d;
      ip_sw_q      <= ip_sw_d;
      ip_hw_q      <= ip_hw_d;
      timer_pend_q <= timer_pend_d;
      epc_q        <= epc_d;
      count_q      <= count_d;
      compare_q    <= compare_d;
    end
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Self-checking bench for cp0_exception_unit: register-level model checked every
// negedge, plus directed scenarios with literal expectations.
module tb_cp0_exception_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        IsCOP0, IsEret, mtc0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        syscall, ri, ov;
  logic [4:0]  ext_int;
  logic [31:0] cp0_rdata;
  logic        HasExp;
  logic [31:0] epc;
  logic        exl;

  int checks = 0;
  int errors = 0;

  cp0_exception_unit dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .IsCOP0    (IsCOP0),
    .IsEret    (IsEret),
    .mtc0_we   (mtc0_we),
    .cp0_addr  (cp0_addr),
    .cp0_wdata (cp0_wdata),
    .syscall   (syscall),
    .ri        (ri),
    .ov        (ov),
    .ext_int   (ext_int),
    .cp0_rdata (cp0_rdata),
    .HasExp    (HasExp),
    .epc       (epc),
    .exl       (exl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: full 32-bit register words, Cause built from fields.
  logic [31:0] m_status, m_epc, m_count, m_compare;
  logic [4:0]  m_exc, m_ext;
  logic [1:0]  m_sw;
  logic        m_tp;
  logic [31:0] n_status, n_epc, n_count, n_compare;
  logic [4:0]  n_exc, n_ext;
  logic [1:0]  n_sw;
  logic        n_tp;

  function automatic logic [7:0] m_ip();
    return {m_tp, m_ext, m_sw};
  endfunction

  function automatic logic m_irq();
    return m_status[0] && !m_status[1] && ((m_ip() & m_status[15:8]) != 8'h0);
  endfunction

  function automatic logic [31:0] m_cause();
    return (32'(m_ip()) << 8) | (32'(m_exc) << 2);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_status = 0; m_epc = 0; m_count = 0; m_compare = 32'hFFFF_FFFF;
    m_exc = 0; m_ext = 0; m_sw = 0; m_tp = 0;
  endtask

  initial begin
    logic has;
    logic [4:0] code;
    m_reset();
    forever begin
      @(negedge clk);
      if (rst) m_reset();
      has = m_irq() || syscall || ri || ov;
      chk("model_HasExp", {31'h0, HasExp}, {31'h0, has});
      chk("model_rdata", cp0_rdata, m_read(cp0_addr));
      chk("model_epc", epc, m_epc);
      chk("model_exl", {31'h0, exl}, {31'h0, m_status[1]});
      n_status = m_status; n_epc = m_epc; n_compare = m_compare;
      n_exc = m_exc; n_sw = m_sw; n_ext = ext_int;
      n_count = m_count + 1;
      n_tp = m_tp || (m_count == m_compare);
      if (has) begin
        code = m_irq() ? 5'd0 : ov ? 5'd12 : ri ? 5'd10 : 5'd8;
        n_exc = code;
        if (!m_status[1]) n_epc = pc;
        n_status = m_status | 32'h2;
      end else begin
        if (mtc0_we) begin
          case (cp0_addr)
            5'd9:  n_count = cp0_wdata;
            5'd11: begin n_compare = cp0_wdata; n_tp = 1'b0; end
            5'd12: n_status = cp0_wdata & 32'h0000_FF03;
            5'd13: n_sw = cp0_wdata[9:8];
            5'd14: n_epc = cp0_wdata;
            default: ;
          endcase
        end
        if (IsCOP0 && IsEret) n_status = n_status & ~32'h2;
      end
      @(posedge clk);
      if (!rst) begin
        m_status = n_status; m_epc = n_epc; m_count = n_count; m_compare = n_compare;
        m_exc = n_exc; m_sw = n_sw; m_ext = n_ext; m_tp = n_tp;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_we = 1; cp0_addr = a; cp0_wdata = d;
    tick();
    mtc0_we = 0; cp0_wdata = 0;
  endtask

  task automatic eret();
    IsCOP0 = 1; IsEret = 1;
    tick();
    IsCOP0 = 0; IsEret = 0;
  endtask

  task automatic rd(input logic [4:0] a, input string name, input logic [31:0] exp);
    cp0_addr = a;
    #1;
    chk(name, cp0_rdata, exp);
  endtask

  initial begin
    rst = 1; pc = 0; IsCOP0 = 0; IsEret = 0; mtc0_we = 0; cp0_addr = 0;
    cp0_wdata = 0; syscall = 0; ri = 0; ov = 0; ext_int = 0;
    #2;
    chk("rst_HasExp", {31'h0, HasExp}, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_exl", {31'h0, exl}, 32'h0);
    rd(5'd11, "rst_compare", 32'hFFFF_FFFF);
    tick(); tick();
    rst = 0;

    // Count wrap and reset-Compare match on the same edge.
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, "count_pre_wrap", 32'hFFFF_FFFF);
    tick();
    rd(5'd9, "count_wrap", 32'h0);
    rd(5'd13, "tp_on_wrap", 32'h0000_8000);
    mtc0(5'd11, 32'h1000_0000);
    rd(5'd13, "tp_cleared", 32'h0);

    // Syscall entry and ERET.
    pc = 32'h40; syscall = 1; #1;
    chk("sys_HasExp", {31'h0, HasExp}, 32'h1);
    tick(); syscall = 0;
    chk("sys_epc", epc, 32'h40);
    chk("sys_exl", {31'h0, exl}, 32'h1);
    rd(5'd13, "sys_cause", 32'h20);
    eret();
    chk("eret_exl", {31'h0, exl}, 32'h0);
    chk("eret_epc", epc, 32'h40);

    // External interrupt through IM2.
    mtc0(5'd12, 32'h401);
    pc = 32'h80; ext_int = 5'b00001; #1;
    chk("int_first_cycle", {31'h0, HasExp}, 32'h0);
    tick();
    chk("int_second_cycle", {31'h0, HasExp}, 32'h1);
    tick();
    rd(5'd13, "int_cause", 32'h400);
    rd(5'd12, "int_status", 32'h403);
    chk("int_masked_by_exl", {31'h0, HasExp}, 32'h0);
    ext_int = 0; tick();
    eret();

    // Timer match and clear.
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    repeat (5) tick();
    rd(5'd13, "tp_before_match", 32'h0);
    tick();
    rd(5'd13, "tp_after_match", 32'h8000);
    mtc0(5'd11, 32'h100);
    rd(5'd13, "tp_write_clear", 32'h0);

    // Nested exception keeps EPC.
    mtc0(5'd12, 32'h2);
    pc = 32'h100; ov = 1; #1;
    chk("nest_HasExp", {31'h0, HasExp}, 32'h1);
    tick(); ov = 0;
    chk("nest_epc", epc, 32'h80);
    rd(5'd13, "nest_cause", 32'h30);
    eret();

    // MTC0 to EPC suppressed by a same-cycle ri.
    pc = 32'h200; ri = 1; mtc0_we = 1; cp0_addr = 5'd14; cp0_wdata = 32'h1234;
    tick(); ri = 0; mtc0_we = 0;
    chk("supp_epc", epc, 32'h200);
    rd(5'd13, "supp_cause", 32'h28);
    eret();

    // Priority among sync sources, then with an enabled software interrupt.
    pc = 32'h300; ov = 1; ri = 1; syscall = 1;
    tick(); ov = 0; ri = 0; syscall = 0;
    rd(5'd13, "prio_sync", 32'h30);
    eret();
    mtc0(5'd13, 32'h100);
    mtc0(5'd12, 32'h101);
    pc = 32'h340; ov = 1; ri = 1; syscall = 1;
    tick(); ov = 0; ri = 0; syscall = 0;
    rd(5'd13, "prio_irq", 32'h100);
    chk("prio_irq_epc", epc, 32'h340);

    // Asynchronous reset in the middle of an exception cycle.
    eret();
    pc = 32'h500; syscall = 1; #1;
    rst = 1; syscall = 0; #1;
    chk("arst_epc", epc, 32'h0);
    chk("arst_exl", {31'h0, exl}, 32'h0);
    chk("arst_HasExp", {31'h0, HasExp}, 32'h0);
    rd(5'd13, "arst_cause", 32'h0);
    tick();
    rst = 0;
    tick();
    chk("arst_after_epc", epc, 32'h0);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
